mac_dsp_pipe: RTL and testbench
===============================

Name: mac_dsp_pipe

Overview:
Parametrised pipelined signed multiply-accumulate unit built on the DSP-slice multiplier structure.
- Accepts a stream of (a, b) samples grouped into frames with valid/ready handshake.
- Accumulates the products of each frame and emits one sum per frame with backpressure.
- Sits between sample sources (filters, correlators) and downstream result consumers.

Parameters:
A_WIDTH, 25, signed width of operand a.
B_WIDTH, 18, signed width of operand b.
ACC_WIDTH, 48, signed accumulator/result width; must be >= A_WIDTH+B_WIDTH (elaboration error otherwise).
PIPE_STAGES, 1, extra product register stages after the input registers (0..4).

Ports:
clk_i  in  1  clock.
rst_i  in  1  synchronous active-high reset.
valid_i  in  1  input sample valid.
ready_o  out  1  block can accept a sample this cycle.
a_i  in  A_WIDTH  signed operand a.
b_i  in  B_WIDTH  signed operand b.
clr_i  in  1  sample starts a new frame; any partial sum is discarded.
last_i  in  1  sample ends the frame.
valid_o  out  1  frame result valid.
ready_i  in  1  downstream accepts result.
acc_o  out  ACC_WIDTH  signed frame sum.
ovf_o  out  1  sticky: signed overflow occurred in this frame.

Behaviour:
- Reset (clk_i edge with rst_i=1): all pipeline valids, accumulator, acc_o, ovf_o and valid_o are 0; the frame state is "new frame". Reset mid-frame drops all in-flight samples and the partial sum with no output.
- Clock enable: ce = !valid_o || ready_i. ready_o = ce. When ce=0, the whole pipeline holds. A sample is accepted on a cycle with valid_i && ready_o.
- Pipeline:
  - Stage 0 registers a, b, clr, last and valid.
  - PIPE_STAGES registers carry the product a*b (A_WIDTH+B_WIDTH bits, sign-extended to ACC_WIDTH) plus the flags.
  - The accumulator stage follows.
  - Bubbles (valid=0) do not alter the accumulator.
- Accumulator: for each valid product p:
  - If clr or the frame state is "new frame": acc = p, ovf = 0.
  - Otherwise: acc = acc + p, and ovf |= signed overflow of the add (operand signs equal and result sign differs).
- After a sample with last=1 is accumulated, the frame state becomes "new frame", so the next sample starts a fresh sum without needing clr.
- Output: when the last sample is accumulated, acc_o, ovf_o and valid_o=1 are registered in the same stage.
  - They are held stable while valid_o && !ready_i.
  - valid_o drops the cycle after handshake unless a new frame result completes that same cycle.
- Latency: with no stall, valid_o rises PIPE_STAGES+2 clocks after acceptance of the last sample. Full throughput is one sample per clock.
- clr=1 and last=1 on the same sample: single-product frame, result = p.
- clr=1 mid-frame: the partial sum is discarded silently and no result is emitted for the aborted frame.
- Overflow arithmetic wraps modulo 2^ACC_WIDTH unless the optional feature is enabled.
- Back-to-back frames: a last sample followed immediately by the next frame's first sample is legal, with no gap required.

Optional Feature:
MAC_SAT_EN.
- Defined: on overflow the accumulator saturates to +(2^(ACC_WIDTH-1)-1) or -2^(ACC_WIDTH-1), following the sign of the operands, and stays clamped until a product of opposite sign brings it back in range. ovf_o is still set sticky.
- Undefined: wrap-around arithmetic and no saturation logic.

Test Plan:
- Reset then idle → valid_o=0, acc_o=0, ovf_o=0, ready_o=1.
- Frame (3,4,clr),(-5,2),(100,100,last), PIPE_STAGES=1, ready_i=1 → acc_o=10002, ovf_o=0, valid_o pulses for one cycle exactly 3 clocks after the last sample is accepted.
- Single sample (-7,6) with clr=1, last=1, then immediately (2,2,last) → two results, -42 then 4, on consecutive cycles.
- Frame of 64 samples each a=-2^24, b=-2^17 (product 2^41), last on the 64th:
  - Without MAC_SAT_EN → acc_o=-2^47, ovf_o=1.
  - With MAC_SAT_EN → acc_o=2^47-1, ovf_o=1.
- Hold ready_i=0 with result (5,5,clr,last) pending while valid_i=1 keeps presenting (1,1,clr,last) → ready_o=0, acc_o=25 held. Release ready_i → 25 consumed, then 1 emitted, and no sample is lost or duplicated.
- Assert rst_i mid-frame after (10,10,clr),(1,1), then send (2,3,last) → the single result is 6, and no result from the aborted frame appears.

Source files
------------

// File: rtl/mac_dsp_pipe.sv
// Pipelined signed multiply-accumulate. Each frame of (a, b) samples produces one sum, with valid/ready on both sides.
// Define MAC_SAT_EN to make the accumulator saturate instead of wrapping.
module mac_dsp_pipe #(
  parameter int A_WIDTH     = 25,
  parameter int B_WIDTH     = 18,
  parameter int ACC_WIDTH   = 48,
  parameter int PIPE_STAGES = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [A_WIDTH-1:0]   a_i,
  input  logic [B_WIDTH-1:0]   b_i,
  input  logic                 clr_i,
  input  logic                 last_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [ACC_WIDTH-1:0] acc_o,
  output logic                 ovf_o
);

  localparam int P_WIDTH = A_WIDTH + B_WIDTH;
  localparam int MSB     = ACC_WIDTH - 1;

  if (ACC_WIDTH < P_WIDTH) begin : g_bad_acc_width
    $error("mac_dsp_pipe: ACC_WIDTH must be >= A_WIDTH+B_WIDTH");
  end
  if (PIPE_STAGES < 0 || PIPE_STAGES > 4) begin : g_bad_pipe_stages
    $error("mac_dsp_pipe: PIPE_STAGES must be in 0..4");
  end

  logic ce;
  assign ce      = !valid_o || ready_i;
  assign ready_o = ce;

  logic signed [A_WIDTH-1:0]   s0_a;
  logic signed [B_WIDTH-1:0]   s0_b;
  logic                        s0_v, s0_clr, s0_last;
  logic signed [P_WIDTH-1:0]   mult;
  logic signed [ACC_WIDTH-1:0] prod0;

  assign mult  = s0_a * s0_b;
  assign prod0 = ACC_WIDTH'(mult);

  logic signed [ACC_WIDTH-1:0] m_p;
  logic                        m_v, m_clr, m_last;

  if (PIPE_STAGES > 0) begin : g_pipe
    logic signed [ACC_WIDTH-1:0] pp    [PIPE_STAGES];
    logic                        pv    [PIPE_STAGES];
    logic                        pclr  [PIPE_STAGES];
    logic                        plast [PIPE_STAGES];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        for (int unsigned i = 0; i < unsigned'(PIPE_STAGES); i++) pv[i] <= 1'b0;
      end else if (ce) begin
        pp[0]    <= prod0;
        pv[0]    <= s0_v;
        pclr[0]  <= s0_clr;
        plast[0] <= s0_last;
        for (int unsigned i = 1; i < unsigned'(PIPE_STAGES); i++) begin
          pp[i]    <= pp[i-1];
          pv[i]    <= pv[i-1];
          pclr[i]  <= pclr[i-1];
          plast[i] <= plast[i-1];
        end
      end
    end

    assign m_p    = pp[PIPE_STAGES-1];
    assign m_v    = pv[PIPE_STAGES-1];
    assign m_clr  = pclr[PIPE_STAGES-1];
    assign m_last = plast[PIPE_STAGES-1];
  end else begin : g_direct
    assign m_p    = prod0;
    assign m_v    = s0_v;
    assign m_clr  = s0_clr;
    assign m_last = s0_last;
  end

  logic signed [ACC_WIDTH-1:0] acc, sum, acc_nxt;
  logic                        ovf, ovf_nxt, add_ovf, new_frame, start;

`ifdef MAC_SAT_EN
  localparam logic [ACC_WIDTH-1:0] SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SAT_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
`endif

  always_comb begin
    sum     = acc + m_p;
    add_ovf = (acc[MSB] == m_p[MSB]) && (sum[MSB] != acc[MSB]);
    start   = m_clr || new_frame;
    acc_nxt = sum;
    ovf_nxt = ovf | add_ovf;
    if (start) begin
      acc_nxt = m_p;
      ovf_nxt = 1'b0;
    end
`ifdef MAC_SAT_EN
    // Clamp direction follows the product sign; a clamped value only leaves the rail on an opposite-sign product.
    else if (add_ovf) begin
      acc_nxt = m_p[MSB] ? SAT_MIN : SAT_MAX;
    end
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s0_v      <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
      new_frame <= 1'b1;
      acc_o     <= '0;
      ovf_o     <= 1'b0;
      valid_o   <= 1'b0;
    end else if (ce) begin
      s0_a    <= a_i;
      s0_b    <= b_i;
      s0_v    <= valid_i;
      s0_clr  <= clr_i;
      s0_last <= last_i;
      if (m_v) begin
        acc       <= acc_nxt;
        ovf       <= ovf_nxt;
        new_frame <= m_last;
      end
      valid_o <= m_v && m_last;
      if (m_v && m_last) begin
        acc_o <= acc_nxt;
        ovf_o <= ovf_nxt;
      end
    end
  end

endmodule

// File: tb/tb_mac_dsp_pipe.sv
// Directed self-checking bench for mac_dsp_pipe (default parameters).
// With MAC_SAT_EN defined, the overflow test expects the saturated value.
module tb_mac_dsp_pipe;

  localparam int AW = 25;
  localparam int BW = 18;
  localparam int CW = 48;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [AW-1:0] a_i = '0;
  logic [BW-1:0] b_i = '0;
  logic          clr_i = 1'b0;
  logic          last_i = 1'b0;
  logic          valid_o;
  logic          ready_i = 1'b1;
  logic [CW-1:0] acc_o;
  logic          ovf_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc_cyc = 0;

  logic signed [CW-1:0] res_acc [$];
  logic                 res_ovf [$];
  int                   res_cyc [$];

  mac_dsp_pipe #(
    .A_WIDTH(AW), .B_WIDTH(BW), .ACC_WIDTH(CW), .PIPE_STAGES(1)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a_i), .b_i(b_i), .clr_i(clr_i), .last_i(last_i),
    .valid_o(valid_o), .ready_i(ready_i), .acc_o(acc_o), .ovf_o(ovf_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst_i && valid_o && ready_i) begin
      res_acc.push_back(acc_o);
      res_ovf.push_back(ovf_o);
      res_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_results();
    res_acc.delete(); res_ovf.delete(); res_cyc.delete();
  endtask

  task automatic send(input logic signed [AW-1:0] a, input logic signed [BW-1:0] b,
                      input logic clr, input logic last);
    int  n = 0;
    bit  done = 0;
    a_i = a; b_i = b; clr_i = clr; last_i = last; valid_i = 1'b1;
    while (!done) begin
      @(negedge clk);
      done = ready_o;
      if (done) last_acc_cyc = cyc;
      tick();
      n++;
      if (!done && n > 50) begin
        checks++; errors++;
        $display("FAIL send_timeout: ready_o stayed %0b for %0d cycles, required 1", ready_o, n);
        done = 1;
      end
    end
    valid_i = 1'b0; clr_i = 1'b0; last_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; ready_i = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;
    tick();
    @(negedge clk);
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b required 0", valid_o); end
    checks++; if (acc_o !== '0) begin errors++; $display("FAIL reset_acc: got %0d required 0", acc_o); end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %0b required 0", ovf_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b required 1", ready_o); end
    tick();
  endtask

  task automatic test_frame();
    int t;
    clear_results();
    send(3, 4, 1, 0);
    send(-5, 2, 0, 0);
    send(100, 100, 0, 1);
    t = last_acc_cyc;
    repeat (8) tick();
    checks++; if (res_acc.size() != 1) begin errors++; $display("FAIL frame_count: got %0d results required 1", res_acc.size()); end
    if (res_acc.size() >= 1) begin
      checks++; if (res_acc[0] !== 48'sd10002) begin errors++; $display("FAIL frame_acc: got %0d required 10002", res_acc[0]); end
      checks++; if (res_ovf[0] !== 1'b0) begin errors++; $display("FAIL frame_ovf: got %0b required 0", res_ovf[0]); end
      checks++; if (res_cyc[0] - t != 3) begin errors++; $display("FAIL frame_latency: got %0d required 3", res_cyc[0] - t); end
    end
  endtask

  task automatic test_back_to_back();
    clear_results();
    send(-7, 6, 1, 1);
    send(2, 2, 0, 1);
    repeat (8) tick();
    checks++; if (res_acc.size() != 2) begin errors++; $display("FAIL b2b_count: got %0d results required 2", res_acc.size()); end
    if (res_acc.size() >= 2) begin
      checks++; if (res_acc[0] !== -48'sd42) begin errors++; $display("FAIL b2b_first: got %0d required -42", res_acc[0]); end
      checks++; if (res_acc[1] !== 48'sd4) begin errors++; $display("FAIL b2b_second: got %0d required 4", res_acc[1]); end
      checks++; if (res_cyc[1] - res_cyc[0] != 1) begin errors++; $display("FAIL b2b_spacing: got %0d required 1", res_cyc[1] - res_cyc[0]); end
    end
  endtask

  task automatic test_overflow();
    logic signed [CW-1:0] expv;
`ifdef MAC_SAT_EN
    expv = 48'sh7FFF_FFFF_FFFF;
`else
    expv = 48'sh8000_0000_0000;
`endif
    clear_results();
    for (int i = 0; i < 64; i++) send(25'sh100_0000, 18'sh2_0000, (i == 0), (i == 63));
    repeat (8) tick();
    checks++; if (res_acc.size() != 1) begin errors++; $display("FAIL ovf_count: got %0d results required 1", res_acc.size()); end
    if (res_acc.size() >= 1) begin
      checks++; if (res_acc[0] !== expv) begin errors++; $display("FAIL ovf_acc: got %0h required %0h", res_acc[0], expv); end
      checks++; if (res_ovf[0] !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %0b required 1", res_ovf[0]); end
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    clear_results();
    ready_i = 1'b0;
    send(5, 5, 1, 1);
    while (n < 10) begin
      @(negedge clk);
      if (valid_o) break;
      n++;
    end
    checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL bp_result_timeout: valid_o got %0b required 1", valid_o); end
    tick();
    a_i = 1; b_i = 1; clr_i = 1'b1; last_i = 1'b1; valid_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (ready_o !== 1'b0) begin errors++; $display("FAIL bp_ready: got %0b required 0", ready_o); end
      checks++; if (acc_o !== 48'd25) begin errors++; $display("FAIL bp_hold_acc: got %0d required 25", acc_o); end
      checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL bp_hold_valid: got %0b required 1", valid_o); end
    end
    tick();
    ready_i = 1'b1;
    tick();
    valid_i = 1'b0; clr_i = 1'b0; last_i = 1'b0;
    repeat (8) tick();
    checks++; if (res_acc.size() != 2) begin errors++; $display("FAIL bp_count: got %0d results required 2", res_acc.size()); end
    if (res_acc.size() >= 2) begin
      checks++; if (res_acc[0] !== 48'sd25) begin errors++; $display("FAIL bp_first: got %0d required 25", res_acc[0]); end
      checks++; if (res_acc[1] !== 48'sd1) begin errors++; $display("FAIL bp_second: got %0d required 1", res_acc[1]); end
    end
  endtask

  task automatic test_reset_midframe();
    clear_results();
    ready_i = 1'b1;
    send(10, 10, 1, 0);
    send(1, 1, 0, 0);
    rst_i = 1'b1;
    repeat (2) tick();
    rst_i = 1'b0;
    send(2, 3, 0, 1);
    repeat (8) tick();
    checks++; if (res_acc.size() != 1) begin errors++; $display("FAIL rst_count: got %0d results required 1", res_acc.size()); end
    if (res_acc.size() >= 1) begin
      checks++; if (res_acc[0] !== 48'sd6) begin errors++; $display("FAIL rst_acc: got %0d required 6", res_acc[0]); end
      checks++; if (res_ovf[0] !== 1'b0) begin errors++; $display("FAIL rst_ovf: got %0b required 0", res_ovf[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_overflow();
    test_backpressure();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
